// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: PC, imem fetch handshake, stall hold, redirect/flush.
// Optional FETCH_PERF_EN adds perf_fetch / perf_flush counters.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_offset,
    input  logic [25:0] jtarget,
    input  logic [31:0] jr_target,
    fetch_stage_if.master imem,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush
`endif
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] inst_d, pc4_d;
    logic            valid_d;
    logic [XLEN-1:0] hold_inst, hold_inst_d;
    logic [XLEN-1:0] hold_pc4, hold_pc4_d;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_plus4_c;
    logic            load_valid_c;
    logic            br_offset_unused;

    // Only the low 30 bits of the sign-extended offset survive the word shift
    assign br_offset_unused = ^br_offset[31:30];

    assign imem.imem_req  = rst_n & (state == S_REQ);
    assign imem.imem_addr = pc;

    assign pc_plus4_c = pc + XLEN'(4);

    always_comb begin
        if (jr)
            target_c = jr_target;
        else if (jump)
            target_c = {if_id_pc4[31:28], jtarget, 2'b00};
        else
            target_c = if_id_pc4 + {br_offset[29:0], 2'b00};
    end

    // Next-state and next-datapath decision: redirect > stall > normal
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        inst_d       = if_id_inst;
        pc4_d        = if_id_pc4;
        valid_d      = if_id_valid;
        hold_inst_d  = hold_inst;
        hold_pc4_d   = hold_pc4;
        load_valid_c = 1'b0;

        if (branch) begin
            pc_d        = target_c;
            inst_d      = NOP_INST;
            valid_d     = 1'b0;
            hold_inst_d = '0;
            hold_pc4_d  = '0;
            state_d     = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_plus4_c;
                        if (stall) begin
                            hold_inst_d = imem.imem_rdata;
                            hold_pc4_d  = pc_plus4_c;
                            state_d     = S_HOLD;
                        end else begin
                            inst_d       = imem.imem_rdata;
                            pc4_d        = pc_plus4_c;
                            valid_d      = 1'b1;
                            load_valid_c = 1'b1;
                        end
                    end else if (!stall) begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_d       = hold_inst;
                        pc4_d        = hold_pc4;
                        valid_d      = 1'b1;
                        load_valid_c = 1'b1;
                        state_d      = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_REQ;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= PC_RESET;
            if_id_inst  <= NOP_INST;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            fetch_busy  <= 1'b0;
            hold_inst   <= '0;
            hold_pc4    <= '0;
        end else begin
            pc          <= pc_d;
            if_id_inst  <= inst_d;
            if_id_pc4   <= pc4_d;
            if_id_valid <= valid_d;
            fetch_busy  <= (state_d == S_HOLD);
            hold_inst   <= hold_inst_d;
            hold_pc4    <= hold_pc4_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (load_valid_c)
                perf_fetch <= perf_fetch + XLEN'(1);
            if (branch)
                perf_flush <= perf_flush + XLEN'(1);
        end
    end
`else
    logic load_valid_unused;
    assign load_valid_unused = load_valid_c;
`endif

endmodule
